// File: rtl/ama_riscv_rf_pkg.sv
// Shared types and constants for the AMA-RISCV multi-port register file.
// Provides the sweep FSM state type and the helper for flat-vector port slicing.
package ama_riscv_rf_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int RF_NUM_REGS = 32;
    localparam int RF_DATA_W   = 32;

    // Base bit offset of element idx inside a flat vector of width-bit elements.
    function automatic int rf_sel(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ama_riscv_rf_rd_port.sv
// One read port: x0 masking, output gating during the clear sweep and, when
// RF_BYPASS_EN is defined, same-cycle forwarding from the write ports.
module ama_riscv_rf_rd_port
    import ama_riscv_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int AW     = 5
`ifdef RF_BYPASS_EN
    ,
    parameter int NR_WR  = 1
`endif
) (
    input  logic              ready,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              busy_bit,
`ifdef RF_BYPASS_EN
    input  logic [NR_WR-1:0]        we,
    input  logic [NR_WR*AW-1:0]     addr_wr,
    input  logic [NR_WR*DATA_W-1:0] data_wr,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr,
`endif
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    logic [DATA_W-1:0] data_sel;
    logic              busy_sel;
    logic              visible;

    assign visible = ready && (addr != '0);

`ifdef RF_BYPASS_EN
    // Ascending scan so the highest-numbered matching write port wins.
    always_comb begin
        data_sel = mem_data;
        busy_sel = busy_bit;
        for (int j = 0; j < NR_WR; j++) begin
            if (we[j] && (addr_wr[rf_sel(j, AW) +: AW] == addr)) begin
                data_sel = data_wr[rf_sel(j, DATA_W) +: DATA_W];
                busy_sel = rsv_en && (rsv_addr == addr);
            end
        end
    end
`else
    always_comb begin
        data_sel = mem_data;
        busy_sel = busy_bit;
    end
`endif

    assign data = visible ? data_sel : '0;
    assign busy = visible ? busy_sel : 1'b0;

endmodule

// File: rtl/ama_riscv_reg_file_mp.sv
// Multi-port integer register file with busy scoreboard and post-reset clear sweep.
// Optional same-cycle write-to-read forwarding is enabled by defining RF_BYPASS_EN.
module ama_riscv_reg_file_mp
    import ama_riscv_rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int DATA_W   = RF_DATA_W,
    parameter int NR_RD    = 2,
    parameter int NR_WR    = 1,
    parameter int AW       = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic [NR_RD*AW-1:0]     addr_rd,
    output logic [NR_RD*DATA_W-1:0] data_rd,
    output logic [NR_RD-1:0]        busy_rd,
    input  logic [NR_WR-1:0]        we,
    input  logic [NR_WR*AW-1:0]     addr_wr,
    input  logic [NR_WR*DATA_W-1:0] data_wr,
    input  logic                    rsv_en,
    input  logic [AW-1:0]           rsv_addr
);

    localparam logic [AW-1:0] LAST_PTR = AW'(NUM_REGS - 1);

    rf_state_t         state_reg, state_next;
    logic [AW-1:0]     clr_ptr_reg, clr_ptr_next;
    logic [NUM_REGS-1:0] busy_reg, busy_next;
    logic [DATA_W-1:0] mem [NUM_REGS];

    // Control state: FSM, sweep pointer and scoreboard.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= CLEAR;
            clr_ptr_reg <= '0;
            busy_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            clr_ptr_reg <= clr_ptr_next;
            busy_reg    <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_ptr_next = clr_ptr_reg;
        case (state_reg)
            CLEAR: begin
                clr_ptr_next = clr_ptr_reg + 1'b1;
                if (clr_ptr_reg == LAST_PTR) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                state_next = RUN;
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    assign ready = (state_reg == RUN);

    // Writes release first, then a reserve in the same cycle re-marks busy.
    always_comb begin
        busy_next = busy_reg;
        if (state_reg == RUN) begin
            for (int j = 0; j < NR_WR; j++) begin
                if (we[j] && (addr_wr[rf_sel(j, AW) +: AW] != '0)) begin
                    busy_next[addr_wr[rf_sel(j, AW) +: AW]] = 1'b0;
                end
            end
            if (rsv_en && (rsv_addr != '0)) begin
                busy_next[rsv_addr] = 1'b1;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Storage: one clearing write per cycle during the sweep, port writes in RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_reg == CLEAR) begin
                mem[clr_ptr_reg] <= '0;
            end else begin
                for (int j = 0; j < NR_WR; j++) begin
                    if (we[j] && (addr_wr[rf_sel(j, AW) +: AW] != '0)) begin
                        mem[addr_wr[rf_sel(j, AW) +: AW]] <=
                            data_wr[rf_sel(j, DATA_W) +: DATA_W];
                    end
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NR_RD; gi++) begin : g_rd
            logic [AW-1:0]     port_addr;
            logic [DATA_W-1:0] port_mem_data;
            logic              port_busy_bit;

            assign port_addr     = addr_rd[rf_sel(gi, AW) +: AW];
            assign port_mem_data = mem[port_addr];
            assign port_busy_bit = busy_reg[port_addr];

            ama_riscv_rf_rd_port #(
                .DATA_W (DATA_W),
                .AW     (AW)
`ifdef RF_BYPASS_EN
                ,
                .NR_WR  (NR_WR)
`endif
            ) u_rd_port (
                .ready    (ready),
                .addr     (port_addr),
                .mem_data (port_mem_data),
                .busy_bit (port_busy_bit),
`ifdef RF_BYPASS_EN
                .we       (we),
                .addr_wr  (addr_wr),
                .data_wr  (data_wr),
                .rsv_en   (rsv_en),
                .rsv_addr (rsv_addr),
`endif
                .data     (data_rd[rf_sel(gi, DATA_W) +: DATA_W]),
                .busy     (busy_rd[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_ama_riscv_reg_file_mp.sv
// Directed table-driven bench for ama_riscv_reg_file_mp (2 read / 2 write ports).
// Expectations for the forwarding case follow RF_BYPASS_EN.
module tb_ama_riscv_reg_file_mp;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          ready;
    logic [2*AW-1:0] addr_rd;
    logic [2*DW-1:0] data_rd;
    logic [1:0]    busy_rd;
    logic [1:0]    we;
    logic [2*AW-1:0] addr_wr;
    logic [2*DW-1:0] data_wr;
    logic          rsv_en;
    logic [AW-1:0] rsv_addr;

    int n_tests = 0;
    int n_fail  = 0;

    ama_riscv_reg_file_mp #(
        .NUM_REGS (32),
        .DATA_W   (DW),
        .NR_RD    (2),
        .NR_WR    (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .addr_rd  (addr_rd),
        .data_rd  (data_rd),
        .busy_rd  (busy_rd),
        .we       (we),
        .addr_wr  (addr_wr),
        .data_wr  (data_wr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  aw0;
        logic [4:0]  aw1;
        logic [31:0] dw0;
        logic [31:0] dw1;
        logic        rsv;
        logic [4:0]  ra;
        logic [4:0]  ar0;
        logic [4:0]  ar1;
        logic [31:0] ed0;
        logic [31:0] ed1;
        logic        eb0;
        logic        eb1;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic [1:0] w, input logic [4:0] a0, input logic [4:0] a1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic r, input logic [4:0] ra,
                                input logic [4:0] r0, input logic [4:0] r1,
                                input logic [31:0] e0, input logic [31:0] e1,
                                input logic b0, input logic b1);
        vec_t v;
        v.we = w;   v.aw0 = a0; v.aw1 = a1; v.dw0 = d0; v.dw1 = d1;
        v.rsv = r;  v.ra = ra;  v.ar0 = r0; v.ar1 = r1;
        v.ed0 = e0; v.ed1 = e1; v.eb0 = b0; v.eb1 = b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = 2'b00;
        rsv_en  = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        addr_rd = {a1, a0};
    endtask

    task automatic wait_ready(output int cycles);
        cycles = 0;
        while (!ready && cycles < 100) begin
            step();
            cycles++;
        end
    endtask

    int cyc;

    initial begin
        rst      = 1'b0;
        we       = '0;
        addr_wr  = '0;
        data_wr  = '0;
        rsv_en   = 1'b0;
        rsv_addr = '0;
        addr_rd  = '0;

        vecs[0]  = mk(2'b11, 5'd7,  5'd7,  32'h11,       32'h22,       1'b0, 5'd0,  5'd7,  5'd7,  32'h22,       32'h22,       1'b0, 1'b0);
        vecs[1]  = mk(2'b11, 5'd0,  5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        1'b0, 1'b0);
        vecs[2]  = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd5,  5'd5,  5'd7,  32'h0,        32'h22,       1'b1, 1'b0);
        vecs[3]  = mk(2'b01, 5'd5,  5'd0,  32'h1234,     32'h0,        1'b0, 5'd0,  5'd5,  5'd5,  32'h1234,     32'h1234,     1'b0, 1'b0);
        vecs[4]  = mk(2'b10, 5'd0,  5'd9,  32'h0,        32'h55,       1'b1, 5'd9,  5'd9,  5'd5,  32'h55,       32'h1234,     1'b1, 1'b0);
        vecs[5]  = mk(2'b00, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1, 5'd9,  5'd9,  5'd9,  32'h55,       32'h55,       1'b1, 1'b1);
        vecs[6]  = mk(2'b11, 5'd10, 5'd11, 32'hA0A0,     32'hB1B1,     1'b0, 5'd0,  5'd10, 5'd11, 32'hA0A0,     32'hB1B1,     1'b0, 1'b0);
        vecs[7]  = mk(2'b01, 5'd12, 5'd12, 32'h0C0C,     32'hFFFF,     1'b0, 5'd0,  5'd12, 5'd7,  32'h0C0C,     32'h22,       1'b0, 1'b0);
        vecs[8]  = mk(2'b11, 5'd9,  5'd0,  32'h99,       32'h77,       1'b0, 5'd0,  5'd9,  5'd0,  32'h99,       32'h0,        1'b0, 1'b0);
        vecs[9]  = mk(2'b11, 5'd14, 5'd15, 32'hE1,       32'hF1,       1'b1, 5'd15, 5'd14, 5'd15, 32'hE1,       32'hF1,       1'b0, 1'b1);
        vecs[10] = mk(2'b00, 5'd16, 5'd16, 32'h1616,     32'h1616,     1'b0, 5'd0,  5'd16, 5'd14, 32'h0,        32'hE1,       1'b0, 1'b0);
        vecs[11] = mk(2'b11, 5'd31, 5'd31, 32'h1,        32'hFFFFFFFF, 1'b0, 5'd0,  5'd31, 5'd30, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0);

        // Power-on reset and first sweep
        step();
        step();
        check("reset ready", {31'b0, ready}, 32'h0);
        check("reset data", data_rd[31:0], 32'h0);
        rst = 1'b1;
        wait_ready(cyc);
        check("first sweep length", cyc, 32);
        $display("[TB] initial sweep done after %0d cycles", cyc);

        // Test 1: fill, reserve x4, then reset pulse and verify sweep
        for (int r = 1; r < 32; r += 2) begin
            we      = 2'b11;
            addr_wr = {5'(r + 1), 5'(r)};
            data_wr = {32'hA5A5A5A5, 32'hA5A5A5A5};
            rsv_en  = (r == 3);
            rsv_addr = 5'd4;
            step();
        end
        idle();
        set_rd(5'd31, 5'd4);
        #1;
        check("fill x31", data_rd[31:0], 32'hA5A5A5A5);
        check("fill x4", data_rd[63:32], 32'hA5A5A5A5);
        check("fill busy x4", {31'b0, busy_rd[1]}, 32'h1);
        $display("[TB] fill x31=0x%08h x4=0x%08h busy=%0b", data_rd[31:0], data_rd[63:32], busy_rd[1]);
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        wait_ready(cyc);
        check("sweep ready latency", cyc, 32);
        for (int r = 0; r < 32; r++) begin
            set_rd(5'(r), 5'(31 - r));
            #1;
            check($sformatf("swept x%0d", r), data_rd[31:0], 32'h0);
            check($sformatf("swept busy x%0d", r), {30'b0, busy_rd}, 32'h0);
        end
        $display("[TB] reset sweep: ready after %0d cycles", cyc);

        // Tests 2-4 and more: table of one-cycle writes/reserves, read back after the edge
        for (int i = 0; i < 12; i++) begin
            we       = vecs[i].we;
            addr_wr  = {vecs[i].aw1, vecs[i].aw0};
            data_wr  = {vecs[i].dw1, vecs[i].dw0};
            rsv_en   = vecs[i].rsv;
            rsv_addr = vecs[i].ra;
            step();
            idle();
            set_rd(vecs[i].ar0, vecs[i].ar1);
            #1;
            check($sformatf("vec%0d rd0", i), data_rd[31:0], vecs[i].ed0);
            check($sformatf("vec%0d rd1", i), data_rd[63:32], vecs[i].ed1);
            check($sformatf("vec%0d busy0", i), {31'b0, busy_rd[0]}, {31'b0, vecs[i].eb0});
            check($sformatf("vec%0d busy1", i), {31'b0, busy_rd[1]}, {31'b0, vecs[i].eb1});
            $display("[TB] vec%0d rd0=0x%08h rd1=0x%08h busy=%b", i, data_rd[31:0], data_rd[63:32], busy_rd);
        end

        // Test 5: same-cycle forwarding
        rsv_en   = 1'b1;
        rsv_addr = 5'd13;
        step();
        idle();
        we      = 2'b11;
        addr_wr = {5'd13, 5'd3};
        data_wr = {32'h1313, 32'hCAFE};
        set_rd(5'd3, 5'd13);
        #1;
`ifdef RF_BYPASS_EN
        check("bypass pre rd0", data_rd[31:0], 32'hCAFE);
        check("bypass pre rd1", data_rd[63:32], 32'h1313);
        check("bypass pre busy1", {31'b0, busy_rd[1]}, 32'h0);
`else
        check("bypass pre rd0", data_rd[31:0], 32'h0);
        check("bypass pre rd1", data_rd[63:32], 32'h0);
        check("bypass pre busy1", {31'b0, busy_rd[1]}, 32'h1);
`endif
        $display("[TB] bypass pre-edge rd0=0x%08h rd1=0x%08h busy=%b", data_rd[31:0], data_rd[63:32], busy_rd);
        step();
        idle();
        #1;
        check("bypass post rd0", data_rd[31:0], 32'hCAFE);
        check("bypass post rd1", data_rd[63:32], 32'h1313);
        check("bypass post busy1", {31'b0, busy_rd[1]}, 32'h0);
        $display("[TB] bypass post-edge rd0=0x%08h rd1=0x%08h busy=%b", data_rd[31:0], data_rd[63:32], busy_rd);

        // Test 6: reset mid-sweep with writes and reserves held during CLEAR
        rst = 1'b0;
        step();
        rst      = 1'b1;
        we       = 2'b11;
        addr_wr  = {5'd20, 5'd2};
        data_wr  = {32'h88, 32'h77};
        rsv_en   = 1'b1;
        rsv_addr = 5'd21;
        set_rd(5'd2, 5'd21);
        for (int c = 0; c < 10; c++) step();
        check("clear rd0 gated", data_rd[31:0], 32'h0);
        check("clear busy1 gated", {31'b0, busy_rd[1]}, 32'h0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        wait_ready(cyc);
        idle();
        check("mid-sweep restart latency", cyc, 32);
        #1;
        check("clear write x2 ignored", data_rd[31:0], 32'h0);
        check("clear rsv x21 ignored", {31'b0, busy_rd[1]}, 32'h0);
        set_rd(5'd20, 5'd21);
        #1;
        check("clear write x20 ignored", data_rd[31:0], 32'h0);
        $display("[TB] mid-sweep restart: ready after %0d cycles, x20=0x%08h", cyc, data_rd[31:0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
